// File: rtl/saber_hit_detector.sv
// -----------------------------------------------------------------------------
// saber_hit_detector
//
// Taps the per-pixel saber/box layer stream that the display path composes and
// scores touches instead of drawing them. Each frame it counts pixels where a
// saber lies over the other fighter's box, and pixels where the two sabers
// overlap (a clash). At every frame close it decides whether this frame is a
// touch candidate. A candidate must repeat for CONFIRM_FRAMES consecutive
// frames before it scores. A score raises a one-cycle hit pulse and then starts
// a cooldown of COOLDOWN_FRAMES frames.
//
// Optional build macro: SABER_HIT_DEBUG_EN
//   defined   -> player/opponent_count_out show the counts latched at the last
//                frame close.
//   undefined -> both count ports are tied to 0 and the debug registers are
//                not built.
//
// Ports:
//   clk_in             pixel clock
//   rst_n_in           synchronous reset, active-low
//   game_active_in     scoring enabled; low holds the block idle
//   active_draw_in     pixel is in the visible area
//   new_frame_in       one-cycle frame-boundary pulse, asserted during blanking
//   player_saber_in    player saber layer pixel (nonzero = present)
//   opponent_saber_in  opponent saber layer pixel (nonzero = present)
//   player_box_in      player box layer pixel (nonzero = present)
//   opponent_box_in    opponent box layer pixel (nonzero = present)
//   player_hit_out     one-cycle pulse: player scored on opponent
//   opponent_hit_out   one-cycle pulse: opponent scored on player
//   clash_out          one-cycle pulse: saber clash in the frame just closed
//   busy_out           high whenever the state is not ARMED
//   state_out          ARMED=0, CONFIRM=1, COOLDOWN=2
//   player_count_out   last frame's player-overlap count (debug)
//   opponent_count_out last frame's opponent-overlap count (debug)
// -----------------------------------------------------------------------------
module saber_hit_detector #(
    parameter int CNT_WIDTH         = 20,
    parameter int OVERLAP_THRESHOLD = 16,
    parameter int CLASH_THRESHOLD   = 8,
    parameter int CONFIRM_FRAMES    = 2,   // 1..15
    parameter int COOLDOWN_FRAMES   = 30   // 1..255
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 game_active_in,
    input  logic                 active_draw_in,
    input  logic                 new_frame_in,
    input  logic [23:0]          player_saber_in,
    input  logic [23:0]          opponent_saber_in,
    input  logic [23:0]          player_box_in,
    input  logic [23:0]          opponent_box_in,
    output logic                 player_hit_out,
    output logic                 opponent_hit_out,
    output logic                 clash_out,
    output logic                 busy_out,
    output logic [1:0]           state_out,
    output logic [CNT_WIDTH-1:0] player_count_out,
    output logic [CNT_WIDTH-1:0] opponent_count_out
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CONFIRM  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] OVL_THR     = CNT_WIDTH'(OVERLAP_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] CLS_THR     = CNT_WIDTH'(CLASH_THRESHOLD);
    localparam logic [3:0]           CONFIRM_N   = 4'(CONFIRM_FRAMES);
    localparam logic [7:0]           COOLDOWN_LM = 8'(COOLDOWN_FRAMES - 1);

    // Stage 1: presence bits and frame timing.
    logic ps_q, os_q, pb_q, ob_q, ad_q, nf_q;

    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers sample their inputs from the same edge, independent of order.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ps_q <= 1'b0;
            os_q <= 1'b0;
            pb_q <= 1'b0;
            ob_q <= 1'b0;
            ad_q <= 1'b0;
            nf_q <= 1'b0;
        end else begin
            ps_q <= |player_saber_in;
            os_q <= |opponent_saber_in;
            pb_q <= |player_box_in;
            ob_q <= |opponent_box_in;
            ad_q <= active_draw_in;
            nf_q <= new_frame_in;
        end
    end

    // Stage 2: qualified overlap pixels.
    logic pov, oov, clv;
    assign pov = ad_q & ps_q & ob_q;
    assign oov = ad_q & os_q & pb_q;
    assign clv = ad_q & ps_q & os_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                     input logic en);
        return (en && (c != CNT_MAX)) ? c + 1'b1 : c;
    endfunction

    logic [CNT_WIDTH-1:0] pov_cnt, oov_cnt, clv_cnt;
    logic [CNT_WIDTH-1:0] pov_lat, oov_lat, clv_lat;
    logic                 close_q;  // latched counts are fresh this cycle

    // A frame close latches the running counts and restarts the counters.
    // A pixel in the close cycle already belongs to the new frame, so the
    // counter restarts from that pixel's contribution rather than from 0.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || !game_active_in) begin
            pov_cnt <= '0;
            oov_cnt <= '0;
            clv_cnt <= '0;
            pov_lat <= '0;
            oov_lat <= '0;
            clv_lat <= '0;
            close_q <= 1'b0;
        end else begin
            close_q <= nf_q;
            if (nf_q) begin
                pov_lat <= pov_cnt;
                oov_lat <= oov_cnt;
                clv_lat <= clv_cnt;
                pov_cnt <= CNT_WIDTH'(pov);
                oov_cnt <= CNT_WIDTH'(oov);
                clv_cnt <= CNT_WIDTH'(clv);
            end else begin
                pov_cnt <= sat_inc(pov_cnt, pov);
                oov_cnt <= sat_inc(oov_cnt, oov);
                clv_cnt <= sat_inc(clv_cnt, clv);
            end
        end
    end

    // Frame evaluation. A clash means the sabers were parried, so it cancels
    // any touch seen in the same frame.
    logic       clash_now;
    logic [1:0] cand;
    assign clash_now = (clv_lat >= CLS_THR);
    assign cand      = clash_now ? 2'b00 : {pov_lat >= OVL_THR, oov_lat >= OVL_THR};

    state_t     state;
    logic [1:0] stored;
    logic [3:0] confirm_cnt;
    logic [7:0] cooldown_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || !game_active_in) begin
            state            <= ARMED;
            stored           <= 2'b00;
            confirm_cnt      <= '0;
            cooldown_cnt     <= '0;
            player_hit_out   <= 1'b0;
            opponent_hit_out <= 1'b0;
            clash_out        <= 1'b0;
        end else begin
            player_hit_out   <= 1'b0;
            opponent_hit_out <= 1'b0;
            clash_out        <= close_q & clash_now;
            if (close_q) begin
                case (state)
                    ARMED: begin
                        if (cand != 2'b00) begin
                            stored      <= cand;
                            confirm_cnt <= 4'd1;
                            if (CONFIRM_N == 4'd1) begin
                                player_hit_out   <= cand[1];
                                opponent_hit_out <= cand[0];
                                cooldown_cnt     <= '0;
                                state            <= COOLDOWN;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (cand == 2'b00) begin
                            state <= ARMED;
                        end else if (cand == stored) begin
                            if (confirm_cnt + 4'd1 == CONFIRM_N) begin
                                player_hit_out   <= stored[1];
                                opponent_hit_out <= stored[0];
                                cooldown_cnt     <= '0;
                                state            <= COOLDOWN;
                            end else begin
                                confirm_cnt <= confirm_cnt + 4'd1;
                            end
                        end else begin
                            stored      <= cand;
                            confirm_cnt <= 4'd1;
                        end
                    end
                    COOLDOWN: begin
                        if (cooldown_cnt == COOLDOWN_LM) begin
                            cooldown_cnt <= '0;
                            state        <= ARMED;
                        end else begin
                            cooldown_cnt <= cooldown_cnt + 8'd1;
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end
    end

    assign state_out = state;
    assign busy_out  = (state != ARMED);

`ifdef SABER_HIT_DEBUG_EN
    logic [CNT_WIDTH-1:0] pdbg_q, odbg_q;

    // Updated on the same edge as the pulses, from the counts just evaluated.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pdbg_q <= '0;
            odbg_q <= '0;
        end else if (close_q) begin
            pdbg_q <= pov_lat;
            odbg_q <= oov_lat;
        end
    end

    assign player_count_out   = pdbg_q;
    assign opponent_count_out = odbg_q;
`else
    assign player_count_out   = '0;
    assign opponent_count_out = '0;
`endif

endmodule

// File: tb/tb_saber_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_saber_hit_detector
//
// Table-driven bench for saber_hit_detector with default parameters. Each table
// record describes one frame (pixel mix plus expected results at that frame's
// close). Expectations are queued when the frame-boundary pulse is driven and
// popped when the DUT's result cycle arrives. Hand sequences cover reset,
// game_active drop mid-confirm, and back-to-back frame pulses.
// -----------------------------------------------------------------------------
module tb_saber_hit_detector;

    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          game_active;
    logic          active_draw;
    logic          new_frame;
    logic [23:0]   player_saber, opponent_saber, player_box, opponent_box;
    logic          player_hit, opponent_hit, clash, busy;
    logic [1:0]    state;
    logic [CW-1:0] player_count, opponent_count;

    saber_hit_detector dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .game_active_in     (game_active),
        .active_draw_in     (active_draw),
        .new_frame_in       (new_frame),
        .player_saber_in    (player_saber),
        .opponent_saber_in  (opponent_saber),
        .player_box_in      (player_box),
        .opponent_box_in    (opponent_box),
        .player_hit_out     (player_hit),
        .opponent_hit_out   (opponent_hit),
        .clash_out          (clash),
        .busy_out           (busy),
        .state_out          (state),
        .player_count_out   (player_count),
        .opponent_count_out (opponent_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       ga_clear;   // drop game_active for one cycle before the frame
        int       pov;
        int       oov;
        int       clv;
        bit       pov_on_nf;  // drive a pov pixel together with new_frame
        bit       ph;
        bit       po;
        bit       cl;
        bit [1:0] st;
        int       pc;
        int       oc;
    } vec_t;

    typedef struct {
        bit       ph;
        bit       po;
        bit       cl;
        bit [1:0] st;
        int       pc;
        int       oc;
    } exp_t;

    vec_t vecs[64];
    int   n_tbl = 0;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit gc, input int pov, input int oov, input int clv,
                       input bit pnf, input bit ph, input bit po, input bit cl,
                       input bit [1:0] st, input int pc, input int oc);
        vecs[n_tbl] = '{gc, pov, oov, clv, pnf, ph, po, cl, st, pc, oc};
        n_tbl++;
    endtask

    task automatic drive(input logic [23:0] ps, input logic [23:0] os,
                         input logic [23:0] pb, input logic [23:0] ob, input logic ad);
        @(negedge clk);
        player_saber = ps; opponent_saber = os; player_box = pb; opponent_box = ob;
        active_draw = ad;
    endtask

    task automatic push_exp(input bit ph, input bit po, input bit cl, input bit [1:0] st,
                            input int pc, input int oc);
        exp_t e;
        e.ph = ph; e.po = po; e.cl = cl; e.st = st;
`ifdef SABER_HIT_DEBUG_EN
        e.pc = pc; e.oc = oc;
`else
        e.pc = 0;  e.oc = 0;
`endif
        sb.push_back(e);
    endtask

    // Compare the DUT's result cycle with the oldest queued expectation.
    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, " player_hit"},   player_hit,   e.ph);
            check({tag, " opponent_hit"}, opponent_hit, e.po);
            check({tag, " clash"},        clash,        e.cl);
            check({tag, " state"},        state,        e.st);
            check({tag, " busy"},         busy,         e.st != 2'd0);
            check({tag, " player_count"}, player_count, e.pc);
            check({tag, " opp_count"},    opponent_count, e.oc);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " pulses_off"}, {player_hit, opponent_hit, clash}, 3'b000);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        if (v.ga_clear) begin
            @(negedge clk); game_active = 1'b0;
            @(negedge clk); game_active = 1'b1;
        end
        for (int i = 0; i < v.pov; i++) drive(24'h800000, 24'h0, 24'h0, 24'h000100, 1'b1);
        for (int i = 0; i < v.oov; i++) drive(24'h0, 24'h010000, 24'h000001, 24'h0, 1'b1);
        for (int i = 0; i < v.clv; i++) drive(24'hFFFFFF, 24'h000080, 24'h0, 24'h0, 1'b1);
        // Distractors: full overlap outside the visible area, lone sabers inside.
        for (int i = 0; i < 3; i++) drive(24'h1, 24'h1, 24'h1, 24'h1, 1'b0);
        for (int i = 0; i < 2; i++) drive(24'h4, 24'h0, 24'h0, 24'h0, 1'b1);
        drive(24'h0, 24'h0, 24'h0, 24'h0, 1'b0);
        // Frame boundary (edge T samples it), result visible after edge T+2.
        @(negedge clk);
        new_frame = 1'b1;
        if (v.pov_on_nf) begin
            player_saber = 24'h000040; opponent_box = 24'h200000; active_draw = 1'b1;
        end
        push_exp(v.ph, v.po, v.cl, v.st, v.pc, v.oc);
        @(negedge clk);
        new_frame = 1'b0;
        player_saber = '0; opponent_box = '0; active_draw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_result(tag);
        @(negedge clk);
        check_quiet(tag);
    endtask

    initial begin
        #5_000_000;
`ifdef SABER_HIT_DEBUG_EN
        #50_000_000;
`endif
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Frame table (CONFIRM_FRAMES=2, COOLDOWN_FRAMES=30).
        add(0, 20, 0, 0, 0,  0, 0, 0, 2'd1, 20, 0);      // first candidate
        add(0, 20, 0, 0, 0,  1, 0, 0, 2'd2, 20, 0);      // confirmed -> score
        for (int i = 0; i < 29; i++)
            add(0, 20, 0, 0, 0,  0, 0, 0, 2'd2, 20, 0);  // cooldown closes 1..29
        add(0, 20, 0, 0, 0,  0, 0, 0, 2'd0, 20, 0);      // cooldown close 30
        add(0, 20, 0, 0, 0,  0, 0, 0, 2'd1, 20, 0);
        add(0, 20, 0, 0, 0,  1, 0, 0, 2'd2, 20, 0);      // scores again
        add(1, 20, 0, 10, 0, 0, 0, 1, 2'd0, 20, 0);      // clash cancels touch
        add(0, 20, 0, 10, 0, 0, 0, 1, 2'd0, 20, 0);
        add(1, 20, 20, 0, 0, 0, 0, 0, 2'd1, 20, 20);     // double touch
        add(0, 20, 20, 0, 0, 1, 1, 0, 2'd2, 20, 20);
        add(0, 0, 0, 8, 0,   0, 0, 1, 2'd2, 0, 0);       // clash at threshold, in cooldown
        add(1, 15, 0, 0, 0,  0, 0, 0, 2'd0, 15, 0);      // just below threshold
        add(0, 16, 0, 0, 0,  0, 0, 0, 2'd1, 16, 0);      // exactly at threshold
        add(0, 0, 16, 0, 0,  0, 0, 0, 2'd1, 0, 16);      // different candidate restarts
        add(0, 0, 16, 0, 0,  0, 1, 0, 2'd2, 0, 16);      // opponent scores
        add(1, 0, 0, 7, 0,   0, 0, 0, 2'd0, 0, 0);       // clash just below threshold
        add(0, 20, 0, 0, 0,  0, 0, 0, 2'd1, 20, 0);
        add(0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 0, 0);       // empty frame drops confirm
        add(0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 0, 0);
        add(1, 15, 0, 0, 1,  0, 0, 0, 2'd0, 15, 0);      // pixel on the boundary...
        add(0, 15, 0, 0, 0,  0, 0, 0, 2'd1, 16, 0);      // ...counts in the new frame

        rst_n = 1'b0; game_active = 1'b1; active_draw = 1'b0; new_frame = 1'b0;
        player_saber = '0; opponent_saber = '0; player_box = '0; opponent_box = '0;
        repeat (4) @(negedge clk);
        check("reset outputs",
              {player_hit, opponent_hit, clash, busy, state, player_count, opponent_count}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < n_tbl; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // game_active drop while confirming: idle next cycle, no pulse, and
        // the stored candidate is forgotten.
        v = '{1, 20, 0, 0, 0, 0, 0, 0, 2'd1, 20, 0};
        run_frame(v, "ga_pre");
        @(negedge clk); game_active = 1'b0;
        @(negedge clk);
        check("ga_drop state", state, 2'd0);
        check("ga_drop busy", busy, 1'b0);
        check_quiet("ga_drop");
        game_active = 1'b1;
        v = '{0, 20, 0, 0, 0, 0, 0, 0, 2'd1, 20, 0};
        run_frame(v, "ga_post");

        // Two consecutive frame pulses with no pixels: each is its own close.
        @(negedge clk); new_frame = 1'b1; push_exp(0, 0, 0, 2'd0, 0, 0);
        @(negedge clk);                   push_exp(0, 0, 0, 2'd0, 0, 0);
        @(negedge clk); new_frame = 1'b0;
        @(negedge clk); check_result("dbl_nf1");
        @(negedge clk); check_result("dbl_nf2");
        @(negedge clk); check_quiet("dbl_nf");

`ifdef SABER_HIT_DEBUG_EN
        // Counter saturation.
        @(negedge clk); game_active = 1'b0;
        @(negedge clk); game_active = 1'b1;
        player_saber = 24'h1; opponent_box = 24'h1; active_draw = 1'b1;
        repeat ((1 << 20) + 5) @(negedge clk);
        player_saber = '0; opponent_box = '0; active_draw = 1'b0;
        @(negedge clk); new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("saturate player_count", player_count, 20'hFFFFF);
        check("saturate state", state, 2'd1);
`endif

        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
